regfile_tagged: RTL and testbench
=================================

# regfile_tagged

Parametrised architectural register file for the out-of-order core. Each register carries a data word, a busy bit and a producer tag (ROB index). It sits between dispatch and commit. Dispatch renames the destination register through the issue port. Commit retires results through the commit port. Operand reads return either committed data or the tag of the pending producer, with same-cycle commit bypass.

## Interface
- XLEN, 32, data width
- NREG, 32, register count; register 0 is hard-wired zero
- AW, $clog2(NREG), register address width
- NREAD, 2, number of read ports
- TAGW, 4, producer tag width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline squash; clears every busy bit
- issue_we  in  1  rename destination register this cycle
- issue_addr  in  AW  destination register being renamed
- issue_tag  in  TAGW  ROB tag of the new producer
- commit_we  in  1  retire a result this cycle
- commit_addr  in  AW  retired destination register
- commit_tag  in  TAGW  ROB tag of the retiring instruction
- commit_data  in  XLEN  retired value
- re  in  NREAD  per-port read enable
- raddr  in  NREAD*AW  packed read addresses; port i uses bits [i*AW +: AW]
- rdata  out  NREAD*XLEN  packed read data
- rbusy  out  NREAD  operand still pending
- rtag  out  NREAD*TAGW  producer tag, valid when rbusy=1

## Operation
- State per register r: data[r] (XLEN), busy[r], tag[r] (TAGW).
- Reset: every data, busy and tag bit is cleared to 0 at the next clk edge.
- While rst=1, all outputs are 0.
- Commit (commit_we=1, commit_addr≠0):
  - data[commit_addr] <= commit_data unconditionally.
  - busy is cleared only if busy=1 and tag[commit_addr]==commit_tag. A newer rename is left pending.
- Issue (issue_we=1, issue_addr≠0, flush=0): busy <= 1, tag <= issue_tag.
- Issue and commit to the same register in the same cycle:
  - Data is written by the commit.
  - Issue wins busy and tag, so the register ends with busy=1 and tag=issue_tag.
- Flush=1:
  - All busy bits are cleared at the edge. Data and tags are kept.
  - A same-cycle commit still writes data.
  - A same-cycle issue is dropped.
- Register 0 is never written. It always reads data 0 with busy 0 and tag 0.
- Read port i (combinational), evaluated in priority order:
  - 1. rst=1, re[i]=0, or raddr=0: outputs 0.
  - 2. Commit this cycle to raddr and the commit would clear busy (per the rule above): rdata=commit_data, rbusy=0 (bypass).
  - 3. Otherwise: rdata=data[raddr], rbusy=busy[raddr], rtag=tag[raddr].
  - When rbusy=0, rtag is driven to 0.
- Same-cycle issue does not affect reads. A dispatching instruction reads its sources before its own rename takes effect.
- Commit to a register that is not busy, or with a mismatched tag, still updates the data. The busy bit is left unchanged.

## Timing
- Write latency: 1 cycle. Issue and commit state is visible to reads from the following cycle.
- Read latency: 0 cycles (combinational).
- Commit bypass is same-cycle.
- Flush takes effect at the clock edge where it is sampled. Reads in that cycle still see pre-flush busy bits.
- Reset mid-operation overrides issue, commit and flush in the same cycle.
- All ports are independent. Any number of read ports may address the same register.

## Structure
- Shared package (defines): ZeroWord, NOPAddr, the True and False constants, and the default TAGW and XLEN.
- One sub-module, regfile_rdport, replicated NREAD times through generate. It implements the read priority/bypass mux for one port.
- Storage is three flat arrays: data, busy and tag.

## Test plan
- Reset: hold rst 2 cycles, then read x5 and x31 on both ports -> rdata=0, rbusy=0, rtag=0.
- Rename then commit:
  - Issue x3 tag 7. Next cycle, read x3 -> rbusy=1, rtag=7.
  - Commit x3 tag 7 data 0xDEADBEEF. In the same cycle, read x3 -> rdata=0xDEADBEEF, rbusy=0 (bypass).
  - Next cycle -> rdata=0xDEADBEEF, rbusy=0.
- Stale commit:
  - Issue x4 tag 2, then issue x4 tag 9.
  - Commit x4 tag 2 data 0x11 -> rdata=0x11, rbusy=1, rtag=9.
  - Commit x4 tag 9 data 0x22 -> rdata=0x22, rbusy=0.
- Simultaneous: issue x6 tag 5 and commit x6 tag 1 data 0x33 in the same cycle, with x6 previously busy tag 1. Next cycle -> rdata=0x33, rbusy=1, rtag=5.
- Flush:
  - Issue x7 and x8 busy.
  - Assert flush together with issue x9 tag 3 -> next cycle x7, x8 and x9 all read rbusy=0. Data for x7 and x8 is unchanged.
- x0: issue x0 tag 4 and commit x0 data 0xFFFF_FFFF -> reads of x0 return data 0, rbusy=0. re=0 on a port -> that port's outputs are 0.

Source files
------------

// File: rtl/regfile_tagged_pkg.sv
// Shared definitions for the tagged architectural register file.
package regfile_tagged_pkg;

  // Default widths used by the register file and its read ports.
  localparam int unsigned DefXlen = 32;
  localparam int unsigned DefTagw = 4;

  // Single-bit truth constants.
  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  // All-zero data word returned by idle, reset or x0 reads.
  localparam logic [DefXlen-1:0] ZeroWord = '0;

  // Register index that is hard-wired to zero and never written.
  localparam int unsigned NOPAddr = 0;

  // An address is backed by storage only when it is below the register count.
  function automatic logic addr_in_range(int unsigned addr, int unsigned nreg);
    return (addr < nreg) ? True : False;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: priority mux between idle/zero, same-cycle commit bypass and stored state.
module regfile_rdport
  import regfile_tagged_pkg::*;
#(
  parameter int unsigned XLEN = DefXlen,
  parameter int unsigned AW   = 5,
  parameter int unsigned TAGW = DefTagw
) (
  input  logic            rst,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  // Commit port, seen combinationally for the bypass.
  input  logic            cmt_we_i,
  input  logic [AW-1:0]   cmt_addr_i,
  input  logic [TAGW-1:0] cmt_tag_i,
  input  logic [XLEN-1:0] cmt_data_i,
  // Stored entry selected by raddr_i.
  input  logic [XLEN-1:0] ent_data_i,
  input  logic            ent_busy_i,
  input  logic [TAGW-1:0] ent_tag_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            rbusy_o,
  output logic [TAGW-1:0] rtag_o
);

  logic idle;
  logic bypass_hit;

  // Idle when held in reset, not enabled, or reading x0.
  always_comb begin
    idle = rst | ~re_i | (raddr_i == AW'(NOPAddr));
  end

  // Bypass only when the commit targets this register and would actually clear its busy bit.
  always_comb begin
    bypass_hit = cmt_we_i & (cmt_addr_i == raddr_i) & ent_busy_i & (ent_tag_i == cmt_tag_i);
  end

  // Output mux in priority order; rtag is forced to zero whenever rbusy is low.
  always_comb begin
    rdata_o = XLEN'(ZeroWord);
    rbusy_o = False;
    rtag_o  = '0;
    if (!idle) begin
      if (bypass_hit) begin
        rdata_o = cmt_data_i;
      end else begin
        rdata_o = ent_data_i;
        rbusy_o = ent_busy_i;
        rtag_o  = ent_busy_i ? ent_tag_i : '0;
      end
    end
  end

endmodule

// File: rtl/regfile_tagged.sv
// Architectural register file with per-register busy bit and producer tag.
// Dispatch renames through the issue port, commit retires through the commit port.
module regfile_tagged
  import regfile_tagged_pkg::*;
#(
  parameter int unsigned XLEN  = DefXlen,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = $clog2(NREG),
  parameter int unsigned NREAD = 2,
  parameter int unsigned TAGW  = DefTagw
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  issue_we_i,
  input  logic [AW-1:0]         issue_addr_i,
  input  logic [TAGW-1:0]       issue_tag_i,
  input  logic                  commit_we_i,
  input  logic [AW-1:0]         commit_addr_i,
  input  logic [TAGW-1:0]       commit_tag_i,
  input  logic [XLEN-1:0]       commit_data_i,
  input  logic [NREAD-1:0]      re_i,
  input  logic [NREAD*AW-1:0]   raddr_i,
  output logic [NREAD*XLEN-1:0] rdata_o,
  output logic [NREAD-1:0]      rbusy_o,
  output logic [NREAD*TAGW-1:0] rtag_o
);

  // Storage: three flat arrays.
  logic [XLEN-1:0] data_q [NREG];
  logic [XLEN-1:0] data_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [TAGW-1:0] tag_q  [NREG];
  logic [TAGW-1:0] tag_d  [NREG];

  logic commit_ok;
  logic issue_ok;

  // Writes to x0 or beyond the register count are discarded.
  always_comb begin
    commit_ok = commit_we_i & (commit_addr_i != AW'(NOPAddr)) &
                addr_in_range(32'(commit_addr_i), NREG);
    issue_ok  = issue_we_i & (issue_addr_i != AW'(NOPAddr)) &
                addr_in_range(32'(issue_addr_i), NREG);
  end

  // Next state: commit writes data and conditionally clears busy; issue (or flush) then
  // overrides busy/tag so a same-cycle rename leaves the register pending on the new tag.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_ok) begin
      data_d[commit_addr_i] = commit_data_i;
      if (busy_q[commit_addr_i] && (tag_q[commit_addr_i] == commit_tag_i)) begin
        busy_d[commit_addr_i] = False;
      end
    end
    if (flush_i) begin
      busy_d = '0;
    end else if (issue_ok) begin
      busy_d[issue_addr_i] = True;
      tag_d[issue_addr_i]  = issue_tag_i;
    end
  end

  // State update with synchronous active-high reset clearing everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '{default: '0};
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rdport
    logic [AW-1:0]   addr;
    logic            in_range;
    logic [XLEN-1:0] ent_data;
    logic            ent_busy;
    logic [TAGW-1:0] ent_tag;

    // Select the stored entry for this port; out-of-range addresses read as empty.
    always_comb begin
      addr     = raddr_i[g*AW +: AW];
      in_range = addr_in_range(32'(addr), NREG);
      ent_data = in_range ? data_q[addr] : '0;
      ent_busy = in_range ? busy_q[addr] : False;
      ent_tag  = in_range ? tag_q[addr]  : '0;
    end

    regfile_rdport #(
      .XLEN (XLEN),
      .AW   (AW),
      .TAGW (TAGW)
    ) u_rdport (
      .rst        (rst),
      .re_i       (re_i[g]),
      .raddr_i    (addr),
      .cmt_we_i   (commit_we_i),
      .cmt_addr_i (commit_addr_i),
      .cmt_tag_i  (commit_tag_i),
      .cmt_data_i (commit_data_i),
      .ent_data_i (ent_data),
      .ent_busy_i (ent_busy),
      .ent_tag_i  (ent_tag),
      .rdata_o    (rdata_o[g*XLEN +: XLEN]),
      .rbusy_o    (rbusy_o[g]),
      .rtag_o     (rtag_o[g*TAGW +: TAGW])
    );
  end

endmodule

// File: tb/tb_regfile_tagged.sv
// Self-checking bench for regfile_tagged: per-cycle model comparison plus directed literals.
module tb_regfile_tagged;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREAD = 2;
  localparam int unsigned TAGW  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush_i;
  logic                  issue_we_i;
  logic [AW-1:0]         issue_addr_i;
  logic [TAGW-1:0]       issue_tag_i;
  logic                  commit_we_i;
  logic [AW-1:0]         commit_addr_i;
  logic [TAGW-1:0]       commit_tag_i;
  logic [XLEN-1:0]       commit_data_i;
  logic [NREAD-1:0]      re_i;
  logic [NREAD*AW-1:0]   raddr_i;
  logic [NREAD*XLEN-1:0] rdata_o;
  logic [NREAD-1:0]      rbusy_o;
  logic [NREAD*TAGW-1:0] rtag_o;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_tagged #(
    .XLEN  (XLEN),
    .NREG  (NREG),
    .AW    (AW),
    .NREAD (NREAD),
    .TAGW  (TAGW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .issue_we_i    (issue_we_i),
    .issue_addr_i  (issue_addr_i),
    .issue_tag_i   (issue_tag_i),
    .commit_we_i   (commit_we_i),
    .commit_addr_i (commit_addr_i),
    .commit_tag_i  (commit_tag_i),
    .commit_data_i (commit_data_i),
    .re_i          (re_i),
    .raddr_i       (raddr_i),
    .rdata_o       (rdata_o),
    .rbusy_o       (rbusy_o),
    .rtag_o        (rtag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state as the spec describes it.
  logic [31:0] m_data [NREG];
  logic        m_busy [NREG];
  logic [3:0]  m_tag  [NREG];

  initial begin
    for (int r = 0; r < int'(NREG); r++) begin
      m_data[r] = '0;
      m_busy[r] = 1'b0;
      m_tag[r]  = '0;
    end
  end

  // Compare every port against the model, then advance the model to the next edge's state.
  always @(negedge clk) begin
    for (int p = 0; p < int'(NREAD); p++) begin
      int          a;
      logic [31:0] ed;
      logic        eb;
      logic [3:0]  et;
      a  = int'(raddr_i[p*AW +: AW]);
      ed = '0;
      eb = 1'b0;
      et = '0;
      if (rst !== 1'b1 && re_i[p] && a != 0) begin
        if (commit_we_i && int'(commit_addr_i) == a && m_busy[a] && m_tag[a] == commit_tag_i) begin
          ed = commit_data_i;
        end else begin
          ed = m_data[a];
          eb = m_busy[a];
          et = m_busy[a] ? m_tag[a] : 4'h0;
        end
      end
      chk($sformatf("model rdata p%0d x%0d", p, a), rdata_o[p*XLEN +: XLEN], ed);
      chk($sformatf("model rbusy p%0d x%0d", p, a), 32'(rbusy_o[p]), 32'(eb));
      chk($sformatf("model rtag p%0d x%0d", p, a), 32'(rtag_o[p*TAGW +: TAGW]), 32'(et));
    end
    if (rst === 1'b1) begin
      for (int r = 0; r < int'(NREG); r++) begin
        m_data[r] = '0;
        m_busy[r] = 1'b0;
        m_tag[r]  = '0;
      end
    end else begin
      logic clear_c;
      int   ca;
      int   ia;
      ca = int'(commit_addr_i);
      ia = int'(issue_addr_i);
      clear_c = commit_we_i && ca != 0 && m_busy[ca] && m_tag[ca] == commit_tag_i;
      if (commit_we_i && ca != 0) m_data[ca] = commit_data_i;
      if (clear_c) m_busy[ca] = 1'b0;
      if (flush_i) begin
        for (int r = 0; r < int'(NREG); r++) m_busy[r] = 1'b0;
      end else if (issue_we_i && ia != 0) begin
        m_busy[ia] = 1'b1;
        m_tag[ia]  = issue_tag_i;
      end
    end
  end

  // Advance to just after the next edge and drop one-shot controls.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    flush_i     = 1'b0;
    issue_we_i  = 1'b0;
    commit_we_i = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    re_i    = 2'b11;
    raddr_i = {a1, a0};
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [3:0] t);
    issue_we_i   = 1'b1;
    issue_addr_i = a;
    issue_tag_i  = t;
  endtask

  task automatic commit(input logic [AW-1:0] a, input logic [3:0] t, input logic [31:0] d);
    commit_we_i   = 1'b1;
    commit_addr_i = a;
    commit_tag_i  = t;
    commit_data_i = d;
  endtask

  // Literal expectation on one port, sampled at the falling edge.
  task automatic expect_port(input string nm, input int p, input logic [31:0] d,
                             input logic b, input logic [3:0] t);
    chk({nm, " rdata"}, rdata_o[p*XLEN +: XLEN], d);
    chk({nm, " rbusy"}, 32'(rbusy_o[p]), 32'(b));
    chk({nm, " rtag"}, 32'(rtag_o[p*TAGW +: TAGW]), 32'(t));
  endtask

  initial begin
    rst           = 1'b1;
    flush_i       = 1'b0;
    issue_we_i    = 1'b0;
    issue_addr_i  = '0;
    issue_tag_i   = '0;
    commit_we_i   = 1'b0;
    commit_addr_i = '0;
    commit_tag_i  = '0;
    commit_data_i = '0;
    re_i          = 2'b11;
    raddr_i       = {5'd31, 5'd5};

    // Reset held two cycles; outputs must be zero throughout.
    @(negedge clk);
    expect_port("in reset p0", 0, 32'h0, 1'b0, 4'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    rd(5'd5, 5'd31);
    @(negedge clk);
    expect_port("after reset x5", 0, 32'h0, 1'b0, 4'h0);
    expect_port("after reset x31", 1, 32'h0, 1'b0, 4'h0);

    // Rename then commit with bypass.
    next_cycle();
    issue(5'd3, 4'd7);
    next_cycle();
    rd(5'd3, 5'd3);
    @(negedge clk);
    expect_port("x3 pending", 0, 32'h0, 1'b1, 4'd7);
    next_cycle();
    commit(5'd3, 4'd7, 32'hDEADBEEF);
    @(negedge clk);
    expect_port("x3 bypass", 1, 32'hDEADBEEF, 1'b0, 4'h0);
    next_cycle();
    @(negedge clk);
    expect_port("x3 committed", 0, 32'hDEADBEEF, 1'b0, 4'h0);

    // Stale commit leaves the newer rename pending.
    next_cycle();
    issue(5'd4, 4'd2);
    next_cycle();
    issue(5'd4, 4'd9);
    next_cycle();
    rd(5'd4, 5'd4);
    commit(5'd4, 4'd2, 32'h11);
    @(negedge clk);
    expect_port("x4 stale commit same cycle", 0, 32'h0, 1'b1, 4'd9);
    next_cycle();
    @(negedge clk);
    expect_port("x4 after stale", 0, 32'h11, 1'b1, 4'd9);
    next_cycle();
    commit(5'd4, 4'd9, 32'h22);
    @(negedge clk);
    expect_port("x4 bypass", 1, 32'h22, 1'b0, 4'h0);
    next_cycle();
    @(negedge clk);
    expect_port("x4 retired", 0, 32'h22, 1'b0, 4'h0);

    // Simultaneous issue and commit to one register.
    next_cycle();
    issue(5'd6, 4'd1);
    next_cycle();
    issue(5'd6, 4'd5);
    commit(5'd6, 4'd1, 32'h33);
    rd(5'd6, 5'd6);
    @(negedge clk);
    expect_port("x6 read ignores issue", 0, 32'h33, 1'b0, 4'h0);
    next_cycle();
    @(negedge clk);
    expect_port("x6 reissued", 0, 32'h33, 1'b1, 4'd5);

    // Flush clears busy, keeps data, drops the same-cycle issue.
    next_cycle();
    commit(5'd7, 4'd0, 32'h77);
    next_cycle();
    commit(5'd8, 4'd0, 32'h88);
    next_cycle();
    issue(5'd7, 4'd1);
    next_cycle();
    issue(5'd8, 4'd2);
    next_cycle();
    flush_i = 1'b1;
    issue(5'd9, 4'd3);
    rd(5'd7, 5'd8);
    @(negedge clk);
    expect_port("x7 pre-flush", 0, 32'h77, 1'b1, 4'd1);
    expect_port("x8 pre-flush", 1, 32'h88, 1'b1, 4'd2);
    next_cycle();
    @(negedge clk);
    expect_port("x7 flushed", 0, 32'h77, 1'b0, 4'h0);
    expect_port("x8 flushed", 1, 32'h88, 1'b0, 4'h0);
    next_cycle();
    rd(5'd9, 5'd9);
    @(negedge clk);
    expect_port("x9 issue dropped", 0, 32'h0, 1'b0, 4'h0);

    // x0 is never written; a disabled port outputs zero.
    next_cycle();
    issue(5'd0, 4'd4);
    commit(5'd0, 4'd4, 32'hFFFF_FFFF);
    rd(5'd0, 5'd0);
    @(negedge clk);
    expect_port("x0 same cycle", 0, 32'h0, 1'b0, 4'h0);
    next_cycle();
    re_i    = 2'b01;
    raddr_i = {5'd7, 5'd0};
    @(negedge clk);
    expect_port("x0 after write", 0, 32'h0, 1'b0, 4'h0);
    expect_port("re=0 port", 1, 32'h0, 1'b0, 4'h0);

    // Reset mid-operation overrides a same-cycle issue and commit.
    next_cycle();
    issue(5'd10, 4'd5);
    next_cycle();
    rst = 1'b1;
    issue(5'd11, 4'd6);
    commit(5'd12, 4'd0, 32'h5);
    rd(5'd10, 5'd3);
    @(negedge clk);
    expect_port("x10 during reset", 0, 32'h0, 1'b0, 4'h0);
    next_cycle();
    rst = 1'b0;
    rd(5'd10, 5'd11);
    @(negedge clk);
    expect_port("x10 after reset", 0, 32'h0, 1'b0, 4'h0);
    expect_port("x11 after reset", 1, 32'h0, 1'b0, 4'h0);
    next_cycle();
    rd(5'd3, 5'd12);
    @(negedge clk);
    expect_port("x3 cleared", 0, 32'h0, 1'b0, 4'h0);
    expect_port("x12 commit dropped", 1, 32'h0, 1'b0, 4'h0);

    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
